// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N_CH-input, WIDTH-bit round-robin multiplexer with valid/ready
// handshakes and a single registered output stage.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   [N_CH]        per-channel word offered
//   in_data    [N_CH*WIDTH]  flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   [N_CH]        per-channel word taken this cycle (at most one set)
//   out_valid                output register holds a word
//   out_data   [WIDTH]       registered word
//   out_ch     [clog2(N_CH)] channel that supplied out_data
//   out_ready                consumer takes the output word this cycle
module rr_mux_reg #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*WIDTH-1:0]    in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_CH)-1:0]  out_ch,
    input  logic                     out_ready
);

    localparam int unsigned CW = $clog2(N_CH);

    logic [CW-1:0]    ptr_q;
    logic [CW-1:0]    ptr_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    out_ch_q;

    logic [N_CH-1:0]  grant;
    logic [CW-1:0]    gidx;
    logic             found;
    logic [CW:0]      scan;
    logic             out_free;
    logic             xfer;

    logic [WIDTH-1:0] ch_data [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Scan channels starting at ptr_q; the index is kept one bit wider so the
    // modulo-N_CH wrap is a single conditional subtract.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan = {1'b0, ptr_q} + (CW+1)'(k);
            if (scan >= (CW+1)'(N_CH)) begin
                scan = scan - (CW+1)'(N_CH);
            end
            if (!found && in_valid[scan[CW-1:0]]) begin
                found                = 1'b1;
                grant[scan[CW-1:0]]  = 1'b1;
                gidx                 = scan[CW-1:0];
            end
        end
    end

    assign out_free = !out_valid_q || out_ready;
    assign xfer     = found && out_free && !rst;
    assign in_ready = (out_free && !rst) ? grant : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gidx == CW'(N_CH - 1)) ? '0 : gidx + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ch_data[gidx];
                out_ch_q    <= gidx;
            end else if (out_ready) begin
                // Word popped with nothing to replace it; data/ch keep last values.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
module tb_rr_mux_reg;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int         m_ptr = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic [1:0] m_ch = '0;

    rr_mux_reg #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (!rst && g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_ch = '0;
    endfunction

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        int g;
        bit free;
        g = model_grant();
        free = !m_valid || out_ready;
        @(posedge clk);
        if (g >= 0 && free) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_ch    = 2'(g);
            m_ptr   = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = '0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1 model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        in_valid = 4'hF;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_init: valid=%b data=%h ch=%0d rdy=%b want 0/00/0/0000",
                     out_valid, out_data, out_ch, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        in_data = 32'h44_33_22_11;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_rdy: got %b want 0001", in_ready);
        end
        @(posedge clk); #1;  // align to post-edge sampling point
        m_valid = 1'b1; m_data = 8'h11; m_ch = 2'd0; m_ptr = 1;
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b ch=%0d data=%h want 1/0/11",
                     out_valid, out_ch, out_data);
        end
        // Mid-stream: hold a word, then reset between edges.
        out_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_async: valid=%b data=%h ch=%0d rdy=%b want 0/00/0/0000",
                     out_valid, out_data, out_ch, in_ready);
        end
        model_reset();
        in_valid = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_stream();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            in_data[2*W +: W] = words[i];
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL single_rdy[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== words[i] || out_ch !== 2'd2) begin
                errors++;
                $display("FAIL single_out[%0d]: valid=%b data=%h ch=%0d want 1/%h/2",
                         i, out_valid, out_data, out_ch, words[i]);
            end
        end
    endtask

    task automatic test_contention();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        in_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(exp_seq[i]) || out_data !== m_data) begin
                errors++;
                $display("FAIL contention[%0d]: valid=%b ch=%0d data=%h want 1/%0d/%h",
                         i, out_valid, out_ch, out_data, exp_seq[i], m_data);
            end
        end
    endtask

    task automatic test_skip_idle();
        int exp_seq [4] = '{1, 3, 1, 3};
        do_reset();
        in_valid = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(exp_seq[i]) || out_data !== m_data) begin
                errors++;
                $display("FAIL skip_idle[%0d]: valid=%b ch=%0d data=%h want 1/%0d/%h",
                         i, out_valid, out_ch, out_data, exp_seq[i], m_data);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_valid = 4'b0001;
        in_data = 32'h00_00_00_A5;
        out_ready = 1'b1;
        tick();
        in_valid = 4'hF;
        in_data = $urandom;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'h0) begin
                errors++;
                $display("FAIL bp_rdy[%0d]: got %b want 0000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d want 1/a5/0",
                         i, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_rdy: got %b want 0010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== in_data[W +: W]) begin
            errors++;
            $display("FAIL bp_release_out: valid=%b ch=%0d data=%h want 1/1/%h",
                     out_valid, out_ch, out_data, in_data[W +: W]);
        end
    endtask

    task automatic test_back_to_back();
        // out_valid is 1 from the previous test.
        in_valid = 4'b1000;
        in_data = 32'h3C_00_00_00;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_rdy: valid=%b rdy=%b want 1/1000", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_out: valid=%b ch=%0d data=%h want 1/3/3c",
                     out_valid, out_ch, out_data);
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h3C || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL drain: valid=%b data=%h ch=%0d want 0/3c/3",
                     out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = 4'($urandom);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL rand_rdy[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== m_ch) begin
                errors++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h ch=%0d want %b/%h/%0d",
                         i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_contention();
        test_skip_idle();
        test_back_pressure();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes, round-robin channel selection and one registered output stage. It is the sequential successor of the 2:1 `mux` primitive: instead of a caller-driven select, it arbitrates fairly among requesting channels and holds its result under back-pressure. It merges several producer streams into one consumer stream in the combinational-logic exercise set.

## Interface
- `N_CH`, default 4: number of input channels; legal range 2..16.
- `WIDTH`, default 8: data width per channel.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input N_CH: bit i set means channel i offers a word.
- `in_data` input N_CH*WIDTH: flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready` output N_CH: bit i set means channel i's word is taken this cycle.
- `out_valid` output 1: the output register holds a word.
- `out_data` output WIDTH: registered word.
- `out_ch` output $clog2(N_CH): index of the channel that supplied `out_data`.
- `out_ready` input 1: consumer accepts the output word this cycle.

## Operation
- Output slot is free when `!out_valid || out_ready` (`out_free`).
- Round-robin pointer `ptr` (0..N_CH-1) names the highest-priority channel.
  - Priority order is ptr, ptr+1, …, wrapping modulo N_CH.
  - Grant is the first channel in that order with `in_valid` set. Grant is one-hot or zero.
- `in_ready[i] = out_free && grant[i]`. At most one `in_ready` bit is high in any cycle.
  - `in_ready` depends combinationally on `in_valid` and `out_ready`. This is permitted for this block.
  - A producer must not make `in_valid` depend on `in_ready`.
- Transfer on channel g (`in_valid[g] && in_ready[g]`), at the next edge:
  - `out_data` ← channel g's data; `out_ch` ← g; `out_valid` ← 1.
  - `ptr` ← (g+1) mod N_CH.
- No transfer and `out_ready` high: `out_valid` ← 0. `out_data` and `out_ch` hold their last values.
- No transfer and `out_ready` low: all state holds.
- While `out_valid && !out_ready`, `out_data` and `out_ch` stay stable and every `in_ready` is 0.
- When no channel is valid, `ptr` does not move. Idle channels are skipped with no bubble.
- Data is never reordered within a channel, and every accepted word appears at the output exactly once.

## Timing
- Reset (asynchronous, takes effect immediately): `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. Channel 0 has first priority after reset.
- `in_ready` is 0 during reset.
- Reset asserted mid-operation discards the word held in the output register. Nothing is replayed.
- Latency is 1 cycle from an accepted input edge to `out_valid`.
- Throughput is one word per cycle while `out_ready` stays high. An output pop and a new accept in the same cycle are both required.
- Fairness: with all channels continuously valid, each channel is granted exactly once every N_CH transfers.
- Pointer wrap: a grant to channel N_CH-1 sets `ptr` to 0.

## Test plan
- Reset: with N_CH=4 and WIDTH=8, assert `rst` mid-stream → `out_valid`, `out_data` and `out_ch` read 0 with no clock edge. After release, with all valid, channel 0 is granted first.
- Single stream: only ch2 valid with data 0x11, 0x22, 0x33 and `out_ready`=1 → `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles; `out_ch`=2 throughout.
- Full contention: all four channels valid and `out_ready`=1 → `out_ch` sequence is 0,1,2,3,0,1 with no idle cycle.
- Skip idle: only ch1 and ch3 valid → `out_ch` alternates 1,3,1,3.
- Back-pressure: hold `out_ready`=0 for 3 cycles with a word 0xA5 from ch0 held → `out_data`=0xA5 stays stable and all `in_ready`=0. The cycle `out_ready` rises, the next grant (ch1) is accepted.
- Pop and accept in the same cycle: with `out_valid`=1 and `out_ready`=1, ch3 is valid → ch3's word appears on the next cycle and `out_valid` stays 1.
